// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - round-robin binary-to-BCD converter driving seven-segment codes
//
// Purpose:
//   Converts NUM_CH unsigned binary channels, one at a time, into DIGITS
//   active-low seven-segment codes per channel using a serial double-dabble.
//   Each channel takes IN_W+2 cycles: LOAD (1), SHIFT (IN_W), WRITE (1).
//   Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   synchronous, active-high
//   value       in   NUM_CH*IN_W packed channel values, channel c at [c*IN_W +: IN_W]
//   hex         out  NUM_CH*DIGITS*7 segment codes, channel c digit d at [(c*DIGITS+d)*7 +: 7]
//   ovf         out  NUM_CH per-channel overflow flags (value > 10^DIGITS-1)
//   frame_done  out  one-cycle pulse after the last channel of a scan is written

module bcd_scan_display #(
   parameter int NUM_CH = 3,
   parameter int IN_W   = 32,
   parameter int DIGITS = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_CH*IN_W-1:0]       value,
   output logic [NUM_CH*DIGITS*7-1:0]   hex,
   output logic [NUM_CH-1:0]            ovf,
   output logic                         frame_done
);

   localparam int BCD_W = DIGITS * 4;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(IN_W + 1);

   localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_W - 1);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SHIFT = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [CH_W-1:0]  ch;
   logic [CNT_W-1:0] cnt;
   logic [IN_W-1:0]  bin;
   logic [BCD_W-1:0] bcd;
   logic             ovf_scr;

   logic [IN_W-1:0]  cur_value;
   logic [BCD_W-1:0] bcd_adj;
   logic [BCD_W-1:0] bcd_shf;
   logic [IN_W-1:0]  bin_shf;
   logic             shift_out;
   logic [DIGITS*7-1:0] fields;

   // Active-low, bit0 = a .. bit6 = g. Non-decimal nibbles only occur after
   // overflow, where the dash override applies anyway.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign cur_value = value[ch*IN_W +: IN_W];

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (cnt == LAST_SHIFT) state_nxt = WRITE;
         WRITE:   state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin} left.
   // The bit leaving the top nibble is a carry into a digit we do not have.
   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[d*4 +: 4] >= 4'd5) begin
            bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
         end
      end
      {shift_out, bcd_shf, bin_shf} = {bcd_adj, bin, 1'b0};
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lead;
`endif

   always_comb begin
      fields = '0;
      for (int d = 0; d < DIGITS; d++) begin
         fields[d*7 +: 7] = ovf_scr ? 7'h3F : seg7(bcd[d*4 +: 4]);
      end
`ifdef LEADING_ZERO_BLANK_EN
      // Walk down from the top digit; blank while every digit so far is zero.
      // Digit 0 is never visited, so a zero value still shows "0".
      lead = 1'b1;
      for (int d = DIGITS - 1; d > 0; d--) begin
         if (bcd[d*4 +: 4] != 4'd0) lead = 1'b0;
         if (lead && !ovf_scr) fields[d*7 +: 7] = 7'h7F;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ch         <= '0;
         cnt        <= '0;
         bin        <= '0;
         bcd        <= '0;
         ovf_scr    <= 1'b0;
         hex        <= {(NUM_CH*DIGITS){7'h7F}};
         ovf        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            LOAD: begin
               bin     <= cur_value;
               bcd     <= '0;
               ovf_scr <= 1'b0;
               cnt     <= '0;
            end
            SHIFT: begin
               bin     <= bin_shf;
               bcd     <= bcd_shf;
               ovf_scr <= ovf_scr | shift_out;
               cnt     <= cnt + CNT_W'(1);
            end
            WRITE: begin
               for (int c = 0; c < NUM_CH; c++) begin
                  if (ch == CH_W'(c)) begin
                     hex[c*DIGITS*7 +: DIGITS*7] <= fields;
                     ovf[c]                      <= ovf_scr;
                  end
               end
               frame_done <= (ch == LAST_CH);
               ch         <= (ch == LAST_CH) ? '0 : ch + CH_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - self-checking bench for bcd_scan_display against a decimal reference model

module tb_bcd_scan_display;

   localparam int NUM_CH = 3;
   localparam int IN_W   = 32;
   localparam int DIGITS = 2;
   localparam int PER    = IN_W + 2;
   localparam int HW     = NUM_CH * DIGITS * 7;

   logic                      clock = 1'b0;
   logic                      reset = 1'b1;
   logic [NUM_CH*IN_W-1:0]    value;
   logic [HW-1:0]             hex;
   logic [NUM_CH-1:0]         ovf;
   logic                      frame_done;

   logic [IN_W-1:0] v [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
      assign value[c*IN_W +: IN_W] = v[c];
   end

   bcd_scan_display #(
      .NUM_CH (NUM_CH),
      .IN_W   (IN_W),
      .DIGITS (DIGITS)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .value      (value),
      .hex        (hex),
      .ovf        (ovf),
      .frame_done (frame_done)
   );

   always #5 clock = ~clock;

   // Reference model: what each display should show, updated on the schedule
   // implied by the per-channel latency (sample at slot start, show at slot end).
   logic [6:0]        m_hex [NUM_CH][DIGITS];
   logic [NUM_CH-1:0] m_ovf;
   logic              m_fd;
   logic [IN_W-1:0]   m_lat;
   int                e = 0;
   int                n_cmp = 0;
   int                n_bad = 0;

   function automatic logic [6:0] seg_of(int n);
      logic [6:0] t [10];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return t[n];
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_show(input int c, input logic [IN_W-1:0] x);
      longint lim;
      longint t;
      int     msd;
      lim = 1;
      for (int i = 0; i < DIGITS; i++) lim = lim * 10;
      if (longint'(x) > lim - 1) begin
         m_ovf[c] = 1'b1;
         for (int d = 0; d < DIGITS; d++) m_hex[c][d] = 7'h3F;
      end else begin
         m_ovf[c] = 1'b0;
         t   = longint'(x);
         msd = 0;
         for (int d = 0; d < DIGITS; d++) begin
            m_hex[c][d] = seg_of(int'(t % 10));
            if (t % 10 != 0) msd = d;
            t = t / 10;
         end
`ifdef LEADING_ZERO_BLANK_EN
         for (int d = msd + 1; d < DIGITS; d++) m_hex[c][d] = 7'h7F;
`endif
      end
   endtask

   task automatic model_edge();
      int pos;
      int c;
      if (reset) begin
         e     = 0;
         m_ovf = '0;
         m_fd  = 1'b0;
         for (int i = 0; i < NUM_CH; i++)
            for (int d = 0; d < DIGITS; d++) m_hex[i][d] = 7'h7F;
      end else begin
         e++;
         pos  = (e - 1) % PER;
         c    = ((e - 1) / PER) % NUM_CH;
         m_fd = 1'b0;
         if (pos == 0) m_lat = v[c];
         if (pos == PER - 1) begin
            model_show(c, m_lat);
            if (c == NUM_CH - 1) m_fd = 1'b1;
         end
      end
   endtask

   task automatic tick();
      logic [HW-1:0] exp_hex;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      for (int i = 0; i < NUM_CH; i++)
         for (int d = 0; d < DIGITS; d++) exp_hex[(i*DIGITS+d)*7 +: 7] = m_hex[i][d];
      check_eq("hex", 64'(hex), 64'(exp_hex));
      check_eq("ovf", 64'(ovf), 64'(m_ovf));
      check_eq("frame_done", 64'(frame_done), 64'(m_fd));
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (e < target && guard < 1000) begin
         tick();
         guard++;
      end
      check_eq("run_to_reached", 64'(e), 64'(target));
   endtask

   logic [6:0] lz;
   int         fd_cnt;

   initial begin
`ifdef LEADING_ZERO_BLANK_EN
      lz = 7'h7F;
`else
      lz = 7'h40;
`endif
      v[0] = 32'd7;
      v[1] = 32'd19;
      v[2] = 32'd100;
      reset = 1'b1;
      repeat (3) tick();
      check_eq("rst_hex", 64'(hex), 64'({(NUM_CH*DIGITS){7'h7F}}));
      check_eq("rst_ovf", 64'(ovf), 64'(0));
      reset = 1'b0;

      // first full scan after release
      fd_cnt = 0;
      for (int i = 0; i < NUM_CH * PER; i++) begin
         tick();
         if (frame_done) fd_cnt++;
      end
      check_eq("scan1_fd_at_end", 64'(frame_done), 64'(1));
      check_eq("scan1_fd_count", 64'(fd_cnt), 64'(1));
      check_eq("scan1_ch0", 64'(hex[13:0]), 64'({lz, 7'h78}));
      check_eq("scan1_ch1", 64'(hex[27:14]), 64'({7'h79, 7'h10}));
      check_eq("scan1_ch2", 64'(hex[41:28]), 64'({7'h3F, 7'h3F}));
      check_eq("scan1_ovf", 64'(ovf), 64'(3'b100));

      // 99 then 0 on ch0
      v[0] = 32'd99;
      tick();
      v[0] = 32'd0;
      run_to(4 * PER);
      check_eq("ch0_99", 64'(hex[13:0]), 64'({7'h10, 7'h10}));
      check_eq("ch0_99_ovf", 64'(ovf[0]), 64'(0));
      run_to(7 * PER);
      check_eq("ch0_zero", 64'(hex[13:0]), 64'({lz, 7'h40}));

      // change during SHIFT does not affect the conversion in flight
      v[0] = 32'd5;
      run_to(9 * PER + 11);
      v[0] = 32'd42;
      run_to(10 * PER);
      check_eq("ch0_sampled5", 64'(hex[13:0]), 64'({lz, 7'h12}));
      run_to(13 * PER);
      check_eq("ch0_42", 64'(hex[13:0]), 64'({7'h19, 7'h24}));

      // one-cycle reset in the middle of ch1 SHIFT
      run_to(13 * PER + 10);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("midrst_hex", 64'(hex), 64'({(NUM_CH*DIGITS){7'h7F}}));
      check_eq("midrst_ovf", 64'(ovf), 64'(0));
      run_to(PER - 1);
      check_eq("midrst_ch0_pending", 64'(hex[13:0]), 64'({7'h7F, 7'h7F}));
      run_to(PER);
      check_eq("midrst_ch0_written", 64'(hex[13:0]), 64'({7'h19, 7'h24}));

      // saturating ch1 then recovery
      v[1] = 32'hFFFF_FFFF;
      run_to(2 * PER);
      check_eq("ch1_ffff_ovf", 64'(ovf[1]), 64'(1));
      check_eq("ch1_ffff_hex", 64'(hex[27:14]), 64'({7'h3F, 7'h3F}));
      v[1] = 32'd10;
      run_to(5 * PER);
      check_eq("ch1_10_ovf", 64'(ovf[1]), 64'(0));
      check_eq("ch1_10_hex", 64'(hex[27:14]), 64'({7'h79, 7'h40}));

      // randomized phase, values changing at arbitrary times, rare resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            int c;
            c = $urandom_range(0, NUM_CH - 1);
            case ($urandom_range(0, 3))
               0:       v[c] = $urandom;
               1:       v[c] = $urandom_range(95, 105);
               default: v[c] = $urandom_range(0, 99);
            endcase
         end
         reset = ($urandom_range(0, 599) == 0);
         tick();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
